// File: rtl/sm_muldiv_pkg.sv
// Shared operation, state and instruction-function encodings for the multiply/divide unit.
package sm_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_DIVU  = 2'b01,
    MD_MTHI  = 2'b10,
    MD_MTLO  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'b00,
    MDS_RUN  = 2'b01,
    MDS_DONE = 2'b10
  } md_state_e;

  // R-type function fields of the instructions served by this unit
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIVU  = 6'h1B;

endpackage

// File: rtl/sm_muldiv_step.sv
// One radix-2 iteration: shift-add multiply (div_i=0) or restoring divide (div_i=1).
module sm_muldiv_step
  import sm_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH:0]     rem_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH:0]     rem_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opb_i} : '0);
    shifted = {rem_i, acc_i[WIDTH-1]};
    trial   = shifted - {2'b00, opb_i};
    acc_o   = acc_i;
    rem_o   = rem_i;
    if (!div_i) begin
      // carry out of the upper-half add becomes the new MSB
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else if (trial[WIDTH+1]) begin
      rem_o             = shifted[WIDTH:0];
      acc_o[WIDTH-1:0]  = {acc_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o             = trial[WIDTH:0];
      acc_o[WIDTH-1:0]  = {acc_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative MULTU/DIVU unit with HI/LO registers; MTHI/MTLO write them directly.
module sm_muldiv
  import sm_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       oper,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_nxt;
  logic [WIDTH:0]     rem_q, rem_d, rem_nxt;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               div_q, div_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               accept;
  md_op_e             op;

  sm_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i (div_q),
    .acc_i (acc_q),
    .rem_i (rem_q),
    .opb_i (opb_q),
    .acc_o (acc_nxt),
    .rem_o (rem_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    opb_d   = opb_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op      = md_op_e'(oper);
    accept  = start && !flush && (state_q != MDS_RUN);

    case (state_q)
      MDS_RUN: begin
        if (flush) begin
          state_d = MDS_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_nxt;
          rem_d = rem_nxt;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = MDS_DONE;
            if (div_q) begin
              hi_d = rem_nxt[WIDTH-1:0];
              lo_d = acc_nxt[WIDTH-1:0];
            end else begin
              hi_d = acc_nxt[2*WIDTH-1:WIDTH];
              lo_d = acc_nxt[WIDTH-1:0];
            end
          end
        end
      end
      default: begin
        state_d = MDS_IDLE;
        if (accept) begin
          case (op)
            MD_MULTU, MD_DIVU: begin
              if (op == MD_DIVU && srcB == '0) begin
                state_d = MDS_DONE;
                hi_d    = srcA;
                lo_d    = '1;
              end else begin
                state_d          = MDS_RUN;
                cnt_d            = CNT_W'(WIDTH);
                acc_d            = '0;
                acc_d[WIDTH-1:0] = srcA;
                rem_d            = '0;
                opb_d            = srcB;
                div_d            = (op == MD_DIVU);
              end
            end
            MD_MTHI: hi_d = srcA;
            default: lo_d = srcA;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MDS_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      opb_q   <= opb_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == MDS_RUN);
  assign done = (state_q == MDS_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/sm_muldiv.md
Name: sm_muldiv

Overview:
Parametrised iterative multiply/divide unit with HI/LO result registers. It is the multi-cycle companion to the single-cycle CPU ALU and implements MULTU, DIVU, MTHI and MTLO. The unit sits beside the ALU in the execute stage and shares its operands (rd1, rd2). The control unit issues an operation with `start`, stalls the PC while `busy` is high, and reads HI/LO for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (legal values: 4..64).
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; not to be overridden).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  issue request; sampled on the rising edge.
oper  in  2  operation: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
srcA  in  WIDTH  multiplicand, dividend, or MTHI/MTLO data.
srcB  in  WIDTH  multiplier or divisor.
flush  in  1  abort the operation in flight.
busy  out  1  iteration in progress; the CPU stalls while it is high.
done  out  1  one-cycle pulse: HI/LO were updated by MULTU/DIVU.
hi  out  WIDTH  HI register (product upper half, or remainder).
lo  out  WIDTH  LO register (product lower half, or quotient).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State becomes IDLE.
  - busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0.
  - Reset during RUN abandons the operation.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 (edge k):
  - MULTU or DIVU with srcB≠0: latch operands, counter=WIDTH, go to RUN. busy=1 in cycles k+1..k+WIDTH.
  - DIVU with srcB=0: no iteration. Go to DONE with hi=srcA and lo=all-ones. done=1 in cycle k+1; busy never rises.
  - MTHI: hi=srcA at edge k. MTLO: lo=srcA at edge k. Stay in or return to IDLE; done is not pulsed.
- RUN: one iteration per cycle; the counter decrements.
  - MULTU: shift-add, radix-2, on a 2*WIDTH accumulator. Each step adds srcB to the upper half when the accumulator LSB is 1, then shifts right by one (the carry is kept).
  - DIVU: restoring division, one quotient bit per cycle. The remainder register is WIDTH+1 bits wide to hold the trial-subtract sign.
  - When the counter reaches 1: commit the result to hi/lo at the next edge and go to DONE.
  - done=1 in cycle k+WIDTH+1 and busy=0 in that cycle. Total latency is WIDTH+1 cycles from the start edge.
- DONE lasts exactly one cycle, then goes to IDLE unless start is accepted. Back-to-back starts are legal, so done and the next busy may overlap by zero cycles.
- start while in RUN: ignored. The CPU must not issue it; it has no effect on state or results.
- flush in RUN: go to IDLE at the next edge. busy=0 in the next cycle, hi/lo keep their pre-start values, done is not pulsed.
- flush in IDLE or DONE: no effect. flush and start together: flush wins and start is dropped.
- hi/lo change only on reset, MTHI/MTLO, or a MULTU/DIVU commit. They never show partial results.
- All arithmetic is unsigned and modulo 2^(2*WIDTH) for the product.

Decomposition:
- Shared include sm_cpu.vh gets:
  - Operation codes: MD_MULTU, MD_DIVU, MD_MTHI, MD_MTLO.
  - State codes: MDS_IDLE, MDS_RUN, MDS_DONE.
  - Opcode/function constants for the new instructions: F_MULTU, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO.
- One combinational sub-module, sm_muldiv_step. It takes the current accumulator, remainder and operand, plus a mode bit, and returns the next accumulator and remainder. This keeps the FSM and datapath separable and lets the step be tested on its own.

Test Plan:
- Basic multiply (WIDTH=32): MULTU, srcA=3, srcB=5 -> busy high for 32 cycles; done in cycle 33; hi=0, lo=15.
- Maximum multiply: MULTU, srcA=srcB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at done.
- Divide by zero: DIVU, srcA=100, srcB=7 -> lo=14, hi=2 in cycle 33. Then DIVU, srcA=0x1234, srcB=0 -> done in the next cycle, busy stays 0; hi=0x1234, lo=0xFFFFFFFF.
- MTHI/MTLO: MTHI 0xAAAA0000 then MTLO 0x5555 -> hi and lo update one edge after each start, done stays 0. Then MULTU 2*2 started, flushed at cycle 10 -> busy=0 next cycle, hi=0xAAAA0000 and lo=0x5555 unchanged, no done.
- Back-to-back and ignored start (WIDTH=8): MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 in cycle 9. A start pulsed mid-RUN is ignored. A start on the done cycle (DIVU 200/3) is accepted -> lo=66, hi=2 nine cycles later.
- Reset mid-operation: assert rst_n=0 asynchronously (between clock edges) in cycle 5 of a DIVU -> busy, done, hi and lo read 0 immediately. After release, the next MULTU 6*7 gives lo=42.
